data_mem_responder: RTL



---
 rtl/mem_pkg.sv | 31 +++
 rtl/lsu_align.sv | 48 ++++
 rtl/data_mem_responder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store
// size codes, the responder state encoding and the store byte-enable helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Lanes touched by a store; the low two funct3 bits encode the size.
  function automatic logic [3:0] byte_en(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: extracts and extends load data from a raw
// RAM word and replicates store data across byte lanes with matching enables.
module lsu_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] raw_word,
  input  logic [XLEN-1:0] store_in,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_data,
  output logic [3:0]      be
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [XLEN-1:0] shifted;

  assign shifted  = raw_word >> {addr_lo, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_W:    load_data = raw_word;
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_sel};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    store_data = store_in;
    case (funct3[1:0])
      2'b00:   store_data = {4{store_in[7:0]}};
      2'b01:   store_data = {2{store_in[15:0]}};
      default: store_data = store_in;
    endcase
  end

  assign be = byte_en(funct3, addr_lo);

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request port, programmable wait states,
// word-organised RAM with byte-enable stores and aligned, extended loads.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int    XLEN      = 32,
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t          state_reg;
  logic [3:0]      cnt_reg;
  logic            we_reg;
  logic [2:0]      f3_reg;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic            rsp_valid_reg;
  logic            rsp_err_reg;
  logic [XLEN-1:0] rd_word_reg;

  logic [XLEN-1:0] ram [DEPTH];

  // With zero wait states the access happens on the accept edge, so the
  // access path looks at the live request while idle and the captured copy otherwise.
  logic            acc_we;
  logic [2:0]      acc_f3;
  logic [XLEN-1:0] acc_addr;
  logic [XLEN-1:0] acc_wdata;
  logic [AW-1:0]   acc_idx;
  logic            acc_err;
  logic            accept;
  logic            do_access;
  logic            f3_bad;

  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] store_data;
  logic [3:0]      be;

  assign acc_we    = (state_reg == IDLE) ? req_we     : we_reg;
  assign acc_f3    = (state_reg == IDLE) ? req_funct3 : f3_reg;
  assign acc_addr  = (state_reg == IDLE) ? req_addr   : addr_reg;
  assign acc_wdata = (state_reg == IDLE) ? req_wdata  : wdata_reg;
  assign acc_idx   = acc_addr[AW+1:2];

  always_comb begin
    f3_bad = 1'b0;
    if (acc_we)
      f3_bad = !(acc_f3 == F3_B || acc_f3 == F3_H || acc_f3 == F3_W);
    else
      f3_bad = (acc_f3 == 3'b011) || (acc_f3 == 3'b110) || (acc_f3 == 3'b111);
  end

  assign acc_err = f3_bad
                 || (acc_f3[1:0] == 2'b01 && acc_addr[0])
                 || (acc_f3[1:0] == 2'b10 && acc_addr[1:0] != 2'b00)
                 || (acc_addr[XLEN-1:2] >= (XLEN-2)'(DEPTH));

  assign accept    = (state_reg == IDLE) && req_valid;
  assign do_access = !rst && ((accept && (LATENCY == 0)) ||
                              (state_reg == WAIT && cnt_reg == 4'd0));

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (acc_f3),
    .addr_lo    (acc_addr[1:0]),
    .raw_word   (rd_word_reg),
    .store_in   (acc_wdata),
    .load_data  (load_data),
    .store_data (store_data),
    .be         (be)
  );

  // RAM port: byte-enable write and registered read share the access edge.
  always_ff @(posedge clk) begin
    if (do_access) begin
      rd_word_reg <= ram[acc_idx];
      if (acc_we && !acc_err) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) ram[acc_idx][8*i +: 8] <= store_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      we_reg        <= 1'b0;
      f3_reg        <= 3'b000;
      addr_reg      <= '0;
      wdata_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            we_reg    <= req_we;
            f3_reg    <= req_funct3;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            if (LATENCY == 0) begin
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= acc_err;
              state_reg     <= RESP;
            end else begin
              cnt_reg   <= CNT_INIT;
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= acc_err;
            state_reg     <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = (rsp_valid_reg && !rsp_err_reg && !we_reg) ? load_data : '0;

endmodule
